// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: drives the data-memory req/ack bus for loads and stores,
// stalls the pipeline while an access is in flight and builds the MEM/WB register.
//
// state | meaning
// IDLE  | pass ALU results to WB, or launch an aligned load/store
// REQ   | bus request held stable, waiting for ack or timeout
// DONE  | access result presented on WB, EX/MEM register advances
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] MEM_aluResult,
    input  logic [31:0] MEM_D,
    input  logic [4:0]  MEM_o_rd3,
    input  logic        i_regWrite,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_size,
    input  logic        i_signExt,
    output logic        o_stall,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_WB_data,
    output logic [4:0]  o_WB_rd3,
    output logic        o_WB_regWrite,
    output logic        o_misalign,
    output logic        o_bus_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0] timer_q, timer_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic [4:0]    wb_rd3_q, wb_rd3_d;
    logic          wb_regwrite_q, wb_regwrite_d;
    logic          misalign_q, misalign_d;
    logic          bus_err_q, bus_err_d;

    logic        access;
    logic        is_store;
    logic        is_load;
    logic        size_byte;
    logic        size_half;
    logic        size_word;
    logic        misaligned;
    logic        timer_expired;
    logic        rd3_nonzero;
    logic [1:0]  addr_lo;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data_c;

    // A store wins when both read and write are flagged.
    assign access        = i_memRead | i_memWrite;
    assign is_store      = i_memWrite;
    assign is_load       = i_memRead & ~i_memWrite;
    assign addr_lo       = MEM_aluResult[1:0];
    assign size_byte     = (i_size == 2'b00);
    assign size_half     = (i_size == 2'b01);
    assign size_word     = i_size[1];
    assign misaligned    = (size_half & addr_lo[0]) | (size_word & (addr_lo != 2'b00));
    assign timer_expired = (timer_q == '0);
    assign rd3_nonzero   = (MEM_o_rd3 != 5'd0);

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = MEM_D;
        if (size_byte) begin
            be_c    = 4'b0001 << addr_lo;
            wdata_c = {4{MEM_D[7:0]}};
        end else if (size_half) begin
            be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{MEM_D[15:0]}};
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (addr_lo)
            2'b00:   rd_byte = i_bus_rdata[7:0];
            2'b01:   rd_byte = i_bus_rdata[15:8];
            2'b10:   rd_byte = i_bus_rdata[23:16];
            default: rd_byte = i_bus_rdata[31:24];
        endcase
        rd_half     = addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        load_data_c = i_bus_rdata;
        if (size_byte) begin
            load_data_c = {{24{i_signExt & rd_byte[7]}}, rd_byte};
        end else if (size_half) begin
            load_data_c = {{16{i_signExt & rd_half[15]}}, rd_half};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (i_bus_ack || timer_expired) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d       = timer_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_be_d      = bus_be_q;
        wb_data_d     = wb_data_q;
        wb_rd3_d      = wb_rd3_q;
        wb_regwrite_d = wb_regwrite_q;
        misalign_d    = 1'b0;
        bus_err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!access) begin
                    wb_data_d     = MEM_aluResult;
                    wb_rd3_d      = MEM_o_rd3;
                    wb_regwrite_d = i_regWrite & rd3_nonzero;
                end else if (misaligned) begin
                    misalign_d    = 1'b1;
                    wb_regwrite_d = 1'b0;
                end else begin
                    bus_req_d     = 1'b1;
                    bus_we_d      = is_store;
                    bus_addr_d    = {MEM_aluResult[31:2], 2'b00};
                    bus_wdata_d   = wdata_c;
                    bus_be_d      = be_c;
                    wb_regwrite_d = 1'b0;
                    timer_d       = TIMER_LOAD;
                end
            end
            S_REQ: begin
                if (i_bus_ack) begin
                    if (is_load) begin
                        wb_data_d = load_data_c;
                    end
                    wb_rd3_d      = MEM_o_rd3;
                    wb_regwrite_d = is_load & i_regWrite & rd3_nonzero;
                    bus_req_d     = 1'b0;
                    bus_we_d      = 1'b0;
                    timer_d       = '0;
                end else if (timer_expired) begin
                    bus_req_d     = 1'b0;
                    bus_we_d      = 1'b0;
                    bus_err_d     = 1'b1;
                    wb_regwrite_d = 1'b0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer_q       <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'd0;
            bus_wdata_q   <= 32'd0;
            bus_be_q      <= 4'd0;
            wb_data_q     <= 32'd0;
            wb_rd3_q      <= 5'd0;
            wb_regwrite_q <= 1'b0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
            wb_data_q     <= wb_data_d;
            wb_rd3_q      <= wb_rd3_d;
            wb_regwrite_q <= wb_regwrite_d;
            misalign_q    <= misalign_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // Stall is gated by reset so every output reads 0 while reset is held.
    assign o_stall = i_rst_n &
                     (((state_q == S_IDLE) & access & ~misaligned) | (state_q == S_REQ));

    assign o_bus_req     = bus_req_q;
    assign o_bus_we      = bus_we_q;
    assign o_bus_addr    = bus_addr_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_bus_be      = bus_be_q;
    assign o_WB_data     = wb_data_q;
    assign o_WB_rd3      = wb_rd3_q;
    assign o_WB_regWrite = wb_regwrite_q;
    assign o_misalign    = misalign_q;
    assign o_bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: ALU pass-through, loads, stores, misalignment,
// bus timeout and asynchronous reset in the middle of a request.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_result;
    logic [31:0] mem_d;
    logic [4:0]  rd3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd3;
    logic        wb_regwrite;
    logic        misalign;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_ctrl #(.TIMEOUT_CYC(64)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .MEM_aluResult (alu_result),
        .MEM_D         (mem_d),
        .MEM_o_rd3     (rd3),
        .i_regWrite    (reg_write),
        .i_memRead     (mem_read),
        .i_memWrite    (mem_write),
        .i_size        (size),
        .i_signExt     (sign_ext),
        .o_stall       (stall),
        .o_bus_req     (bus_req),
        .o_bus_we      (bus_we),
        .o_bus_addr    (bus_addr),
        .o_bus_wdata   (bus_wdata),
        .o_bus_be      (bus_be),
        .i_bus_ack     (bus_ack),
        .i_bus_rdata   (bus_rdata),
        .o_WB_data     (wb_data),
        .o_WB_rd3      (wb_rd3),
        .o_WB_regWrite (wb_regwrite),
        .o_misalign    (misalign),
        .o_bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        alu_result = 32'd0;
        mem_d      = 32'd0;
        rd3        = 5'd0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        size       = 2'b00;
        sign_ext   = 1'b0;
        bus_ack    = 1'b0;
        bus_rdata  = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        #12;
        chk("rst_req", bus_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_wb_we", wb_regwrite, 1'b0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        rst_n = 1'b1;
        step();

        // ALU pass-through
        alu_result = 32'h0000_1234; rd3 = 5'd5; reg_write = 1'b1;
        #1 chk("alu_stall", stall, 1'b0);
        step();
        chk("alu_wb_data", wb_data, 32'h0000_1234);
        chk("alu_wb_rd3", wb_rd3, 5'd5);
        chk("alu_wb_we", wb_regwrite, 1'b1);
        chk("alu_stall2", stall, 1'b0);
        // rd3 = 0 never writes back
        rd3 = 5'd0;
        step();
        chk("alu_r0_we", wb_regwrite, 1'b0);
        nop();

        // lb 0x103 sign-extended, ack in second REQ cycle
        alu_result = 32'h0000_0103; mem_read = 1'b1; size = 2'b00; sign_ext = 1'b1;
        rd3 = 5'd7; reg_write = 1'b1;
        #1 chk("lb_stall_idle", stall, 1'b1);
        step();
        chk("lb_req", bus_req, 1'b1);
        chk("lb_we", bus_we, 1'b0);
        chk("lb_be", bus_be, 4'b1000);
        chk("lb_addr", bus_addr, 32'h0000_0100);
        chk("lb_bubble", wb_regwrite, 1'b0);
        chk("lb_stall_req1", stall, 1'b1);
        step();
        chk("lb_req_hold", bus_req, 1'b1);
        chk("lb_stall_req2", stall, 1'b1);
        bus_ack = 1'b1; bus_rdata = 32'h80FF_FFFF;
        step();
        bus_ack = 1'b0;
        chk("lb_done_stall", stall, 1'b0);
        chk("lb_done_req", bus_req, 1'b0);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_wb_rd3", wb_rd3, 5'd7);
        chk("lb_wb_we", wb_regwrite, 1'b1);
        nop();
        step();
        chk("lb_post_req", bus_req, 1'b0);
        chk("lb_hold_data", wb_data, 32'hFFFF_FF80);

        // sh 0x202, stored half replicated to both halves
        alu_result = 32'h0000_0202; mem_d = 32'hAAAA_BEEF; size = 2'b01; mem_write = 1'b1;
        rd3 = 5'd9; reg_write = 1'b1;
        #1 chk("sh_stall", stall, 1'b1);
        step();
        chk("sh_req", bus_req, 1'b1);
        chk("sh_we", bus_we, 1'b1);
        chk("sh_be", bus_be, 4'b1100);
        chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", bus_addr, 32'h0000_0200);
        step();
        chk("sh_req_hold", bus_req, 1'b1);
        chk("sh_wdata_hold", bus_wdata, 32'hBEEF_BEEF);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        chk("sh_done_req", bus_req, 1'b0);
        chk("sh_wb_we", wb_regwrite, 1'b0);
        chk("sh_done_stall", stall, 1'b0);
        nop();
        step();

        // sb at 0x001 with read also set: treated as store, ack in first REQ cycle
        alu_result = 32'h0000_0001; mem_d = 32'h1234_565A; size = 2'b00;
        mem_read = 1'b1; mem_write = 1'b1; rd3 = 5'd2; reg_write = 1'b1;
        step();
        chk("sb_we", bus_we, 1'b1);
        chk("sb_be", bus_be, 4'b0010);
        chk("sb_wdata", bus_wdata, 32'h5A5A_5A5A);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_ack = 1'b0;
        chk("sb_wb_we", wb_regwrite, 1'b0);
        chk("sb_wb_data", wb_data, 32'hFFFF_FF80);
        chk("sb_done_stall", stall, 1'b0);
        nop();
        step();
        chk("sb_no_rereq", bus_req, 1'b0);

        // lhu 0x006 zero-extended from the upper half
        alu_result = 32'h0000_0006; size = 2'b01; mem_read = 1'b1; sign_ext = 1'b0;
        rd3 = 5'd10; reg_write = 1'b1;
        step();
        chk("lhu_be", bus_be, 4'b1100);
        chk("lhu_addr", bus_addr, 32'h0000_0004);
        bus_ack = 1'b1; bus_rdata = 32'h8001_1234;
        step();
        bus_ack = 1'b0;
        chk("lhu_wb_data", wb_data, 32'h0000_8001);
        chk("lhu_wb_we", wb_regwrite, 1'b1);
        nop();
        step();

        // lw misaligned at 0x301
        alu_result = 32'h0000_0301; size = 2'b10; mem_read = 1'b1; rd3 = 5'd3; reg_write = 1'b1;
        #1 chk("mis_stall", stall, 1'b0);
        step();
        chk("mis_pulse", misalign, 1'b1);
        chk("mis_req", bus_req, 1'b0);
        chk("mis_wb_we", wb_regwrite, 1'b0);
        nop();
        step();
        chk("mis_pulse_end", misalign, 1'b0);

        // lw with no ack: timeout after 64 REQ cycles
        alu_result = 32'h0000_0400; size = 2'b10; mem_read = 1'b1; rd3 = 5'd4; reg_write = 1'b1;
        step();
        chk("to_req_first", bus_req, 1'b1);
        repeat (63) step();
        chk("to_req_last", bus_req, 1'b1);
        chk("to_err_early", bus_err, 1'b0);
        chk("to_stall_last", stall, 1'b1);
        step();
        chk("to_req_drop", bus_req, 1'b0);
        chk("to_err", bus_err, 1'b1);
        chk("to_wb_we", wb_regwrite, 1'b0);
        chk("to_done_stall", stall, 1'b0);
        nop();
        step();
        chk("to_err_end", bus_err, 1'b0);
        chk("to_idle_stall", stall, 1'b0);
        chk("to_idle_req", bus_req, 1'b0);

        // asynchronous reset in the middle of a request
        alu_result = 32'h0000_0500; size = 2'b10; mem_read = 1'b1; rd3 = 5'd6; reg_write = 1'b1;
        step();
        chk("rr_req", bus_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_req_drop", bus_req, 1'b0);
        chk("rr_stall", stall, 1'b0);
        nop();
        #1 rst_n = 1'b1;
        // stray ack while idle must be ignored
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        step();
        bus_ack = 1'b0;
        chk("stray_req", bus_req, 1'b0);
        chk("stray_wb_data", wb_data, 32'd0);
        chk("stray_wb_we", wb_regwrite, 1'b0);
        alu_result = 32'h0000_0500; size = 2'b10; mem_read = 1'b1; rd3 = 5'd6; reg_write = 1'b1;
        step();
        chk("rr_lw_req", bus_req, 1'b1);
        chk("rr_lw_be", bus_be, 4'b1111);
        bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
        step();
        bus_ack = 1'b0;
        chk("rr_lw_data", wb_data, 32'h1122_3344);
        chk("rr_lw_rd3", wb_rd3, 5'd6);
        chk("rr_lw_we", wb_regwrite, 1'b1);
        nop();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
